// File: rtl/maxpool_stream_pkg.sv
// Shared definitions for the max-pool stage, also usable by the conv block:
// default geometry, the signed sample type, the signed maximum helper, the
// output-state encoding and the number of pooled outputs per frame.
package maxpool_stream_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_LENY   = 5;
  localparam int DEF_POOL   = 2;
  localparam int DEF_LOGLEN = 3;

  // ceil(LENY/POOL): the final window may be partial and is still emitted.
  localparam int NUM_OUT = (DEF_LENY + DEF_POOL - 1) / DEF_POOL;

  typedef logic signed [DEF_WIDTH-1:0] sample_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic sample_t signed_max(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_stream_frame_counter.sv
// pool_frame_counter: position tracking for the max-pool stage.
// Holds the sample-in-frame count and the sample-in-window count.
// Ports:
//   clk, reset   - clock, async active-low reset
//   inc          - one sample accepted this cycle
//   win_first    - current sample opens a new window
//   complete_win - current sample closes a window (full stride or frame end)
//   frame_end    - current sample is the last of the frame
module pool_frame_counter #(
  parameter int LENY   = 5,
  parameter int POOL   = 2,
  parameter int LOGLEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output logic win_first,
  output logic complete_win,
  output logic frame_end
);

  logic [LOGLEN-1:0] in_cnt_q, in_cnt_d;
  logic [LOGLEN-1:0] win_cnt_q, win_cnt_d;

  assign frame_end    = (in_cnt_q == LOGLEN'(LENY - 1));
  // A short trailing window closes on frame end rather than on stride.
  assign complete_win = (win_cnt_q == LOGLEN'(POOL - 1)) || frame_end;
  assign win_first    = (win_cnt_q == '0);

  always_comb begin
    in_cnt_d  = in_cnt_q;
    win_cnt_d = win_cnt_q;
    if (inc) begin
      win_cnt_d = complete_win ? '0 : win_cnt_q + 1'b1;
      in_cnt_d  = frame_end    ? '0 : in_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt_q  <= '0;
      win_cnt_q <= '0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      win_cnt_q <= win_cnt_d;
    end
  end

endmodule

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 1-D max-pool, one signed max per POOL-sample
// window, partial final window flushed and tagged last.
// Ports:
//   clk, reset                          - clock, async active-low reset
//   s_data_in_y/s_valid_y/s_ready_y     - input sample stream
//   m_data_out_z/m_valid_z/m_ready_z    - pooled output stream
//   m_last_z                            - final pooled output of a frame
//
// state | meaning
// EMPTY | output register free, input accepted freely
// FULL  | output register holds a result awaiting pop
module maxpool_stream
  import maxpool_stream_pkg::*;
#(
  parameter int LENY   = DEF_LENY,
  parameter int POOL   = DEF_POOL,
  parameter int LOGLEN = DEF_LOGLEN
) (
  input  logic    clk,
  input  logic    reset,
  input  sample_t s_data_in_y,
  input  logic    s_valid_y,
  output logic    s_ready_y,
  output sample_t m_data_out_z,
  output logic    m_valid_z,
  input  logic    m_ready_z,
  output logic    m_last_z
);

  out_state_e state_q, state_d;
  sample_t    max_q, max_d;
  sample_t    out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  sample_t    cand;
  logic       acc, pop, complete;
  logic       win_first, complete_win, frame_end;

  pool_frame_counter #(
    .LENY   (LENY),
    .POOL   (POOL),
    .LOGLEN (LOGLEN)
  ) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .inc          (acc),
    .win_first    (win_first),
    .complete_win (complete_win),
    .frame_end    (frame_end)
  );

  // Ready looks through a full register when downstream pops this cycle,
  // giving one sample per cycle sustained.
  assign s_ready_y = reset && ((state_q == EMPTY) || m_ready_z);
  assign acc       = s_valid_y && s_ready_y;
  assign pop       = (state_q == FULL) && m_ready_z;
  assign complete  = acc && complete_win;
  assign cand      = win_first ? s_data_in_y : signed_max(max_q, s_data_in_y);

  always_comb begin
    state_d    = state_q;
    max_d      = max_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    case (state_q)
      EMPTY: if (complete) state_d = FULL;
      FULL:  if (pop && !complete) state_d = EMPTY;
    endcase
    if (acc && !complete) max_d = cand;
    if (complete) begin
      out_data_d = cand;
      out_last_d = frame_end;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      max_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      max_q      <= max_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  assign m_valid_z    = (state_q == FULL);
  assign m_data_out_z = out_data_q;
  assign m_last_z     = out_last_q;

endmodule

// File: tb/tb_maxpool_stream.sv
module tb_maxpool_stream;
  import maxpool_stream_pkg::*;

  localparam int LENY = 5;
  localparam int BUDGET = 3000;

  logic    clk = 1'b0;
  logic    rst_n;
  sample_t s_data;
  logic    s_valid, m_ready, sel;

  logic    rdy0, val0, last0, rdy1, val1, last1;
  sample_t dat0, dat1;
  logic    obs_ready, obs_valid, obs_last;
  sample_t obs_data;

  int checks = 0;
  int errors = 0;
  int stim[$];
  int exp_d[$];
  int exp_l[$];
  int popped;

  always #5 clk = ~clk;

  maxpool_stream #(.LENY(LENY), .POOL(2), .LOGLEN(3)) dut (
    .clk(clk), .reset(rst_n),
    .s_data_in_y(s_data), .s_valid_y(s_valid && !sel), .s_ready_y(rdy0),
    .m_data_out_z(dat0), .m_valid_z(val0), .m_ready_z(m_ready), .m_last_z(last0)
  );

  maxpool_stream #(.LENY(LENY), .POOL(1), .LOGLEN(3)) dut1 (
    .clk(clk), .reset(rst_n),
    .s_data_in_y(s_data), .s_valid_y(s_valid && sel), .s_ready_y(rdy1),
    .m_data_out_z(dat1), .m_valid_z(val1), .m_ready_z(m_ready), .m_last_z(last1)
  );

  assign obs_ready = sel ? rdy1  : rdy0;
  assign obs_valid = sel ? val1  : val0;
  assign obs_data  = sel ? dat1  : dat0;
  assign obs_last  = sel ? last1 : last0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: each frame split into POOL-sized windows, last one may be short.
  task automatic build_model(input int pool);
    exp_d.delete();
    exp_l.delete();
    for (int f = 0; f * LENY < stim.size(); f++) begin
      for (int w = 0; w < LENY; w += pool) begin
        int m;
        m = stim[f*LENY + w];
        for (int k = w + 1; k < w + pool && k < LENY; k++)
          if (stim[f*LENY + k] > m) m = stim[f*LENY + k];
        exp_d.push_back(m);
        exp_l.push_back((w + pool >= LENY) ? 1 : 0);
      end
    end
  endtask

  // rmode: 0 ready always, 1 random, 2 low for 4 cycles after first output
  // vmode: 0 valid always, 1 random gaps
  task automatic run_stream(input int pool, input int rmode, input int vmode);
    int  n, nexp, sent, got, cyc, stall_left, k;
    bit  stall_started, pend_complete, held, acc, pop;
    sample_t held_d;
    logic    held_l;
    build_model(pool);
    n = stim.size();
    nexp = exp_d.size();
    sent = 0; got = 0; cyc = 0; stall_left = 0;
    stall_started = 0; pend_complete = 0; held = 0;
    held_d = '0; held_l = 1'b0;
    while ((sent < n || got < nexp) && cyc < BUDGET) begin
      @(negedge clk);
      if (pend_complete) chk("latency_valid", obs_valid, 1);
      if (held) begin
        chk("hold_data", obs_data, held_d);
        chk("hold_last", obs_last, held_l);
      end
      if (rmode == 2 && !stall_started && obs_valid) begin
        stall_started = 1;
        stall_left = 4;
      end
      s_valid = (sent < n) && (vmode == 0 || $urandom_range(0, 3) != 0);
      s_data  = (sent < n) ? sample_t'(stim[sent]) : '0;
      if (rmode == 0)      m_ready = 1'b1;
      else if (rmode == 1) m_ready = ($urandom_range(0, 2) != 0);
      else begin
        m_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      #1;
      chk("s_ready", obs_ready, (!obs_valid || m_ready) ? 1 : 0);
      acc = s_valid && obs_ready;
      pop = obs_valid && m_ready;
      if (pop) begin
        if (got < nexp) begin
          chk("out_data", obs_data, exp_d[got]);
          chk("out_last", obs_last, exp_l[got]);
        end else begin
          chk("unexpected_output", 1, 0);
        end
        got++;
        popped++;
      end
      held = obs_valid && !pop;
      held_d = obs_data;
      held_l = obs_last;
      k = sent % LENY;
      pend_complete = acc && ((k % pool == pool - 1) || (k == LENY - 1));
      if (acc) sent++;
      cyc++;
    end
    chk("timeout", (cyc < BUDGET) ? 1 : 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    if (pend_complete) begin
      chk("latency_valid", obs_valid, 1);
      @(negedge clk);
    end
    chk("drained", obs_valid, 0);
  endtask

  initial begin
    int vals[3] = '{3, 7, -2};
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; sel = 1'b0;
    popped = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", val0, 0);
    chk("rst_last", last0, 0);
    chk("rst_data", dat0, 0);
    chk("rst_ready", rdy0, 0);
    chk("rst_valid_p1", val1, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", rdy0, 1);

    // Basic frame, one per cycle
    stim = {3, 7, -2, 1, 5};
    popped = 0;
    run_stream(2, 0, 0);
    chk("frame_outputs", popped, NUM_OUT);

    // Downstream stall after first output
    run_stream(2, 2, 0);

    // All-negative frame, includes most negative value
    stim = {-8, -3, -128, -1, -50};
    run_stream(2, 0, 0);

    // Random back-to-back frames with random handshakes
    stim.delete();
    for (int i = 0; i < 4 * LENY; i++) stim.push_back(int'($urandom_range(0, 255)) - 128);
    run_stream(2, 1, 1);
    run_stream(2, 0, 0);

    // Asynchronous reset with an output pending
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = sample_t'(vals[i]);
    end
    @(negedge clk);
    chk("pend_valid", val0, 1);
    chk("pend_data", dat0, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", val0, 0);
    chk("async_last", last0, 0);
    chk("async_ready", rdy0, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stim = {1, 2, 3, 4, 5};
    run_stream(2, 0, 0);

    // POOL=1 pass-through, two frames back-to-back
    sel = 1'b1;
    stim = {10, -20, 30, -128, 127, 0, -1, 1, 64, -64};
    popped = 0;
    run_stream(1, 0, 0);
    chk("p1_outputs", popped, 10);
    stim.delete();
    for (int i = 0; i < 2 * LENY; i++) stim.push_back(int'($urandom_range(0, 255)) - 128);
    run_stream(1, 1, 1);
    sel = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
